// File: rtl/alu_share_ctrl_if.sv
// Request/response channel bundle between two requesters and the shared-ALU controller.
// The master modport is the requester side; the slave modport is the controller side.
interface alu_share_ctrl_if #(
  parameter int DWL  = 32,
  parameter int SHW  = 5,
  parameter int SELW = 4
) ();
  logic            req_valid_0;
  logic            req_valid_1;
  logic            req_ready_0;
  logic            req_ready_1;
  logic [SELW-1:0] req_sel_0;
  logic [SELW-1:0] req_sel_1;
  logic [DWL-1:0]  req_a_0;
  logic [DWL-1:0]  req_a_1;
  logic [DWL-1:0]  req_b_0;
  logic [DWL-1:0]  req_b_1;
  logic [SHW-1:0]  req_shamt_0;
  logic [SHW-1:0]  req_shamt_1;
  logic            rsp_valid_0;
  logic            rsp_valid_1;
  logic            rsp_ready_0;
  logic            rsp_ready_1;
  logic [DWL-1:0]  rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid_0, req_valid_1, req_sel_0, req_sel_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           req_shamt_0, req_shamt_1, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_data, rsp_err
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_sel_0, req_sel_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           req_shamt_0, req_shamt_1, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
           rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin time-sharing of one combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP; the ALU inputs are registered, its result captured in EXEC.
module alu_share_ctrl #(
  parameter int DWL  = 32,
  parameter int SHW  = 5,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_ctrl_if.slave bus,
  output logic [DWL-1:0]  alu_in1,
  output logic [DWL-1:0]  alu_in2,
  output logic [SHW-1:0]  alu_shamt,
  output logic [SELW-1:0] alu_sel,
  input  logic [DWL-1:0]  alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [SELW-1:0] SEL_ILL_A = SELW'(13);
  localparam logic [SELW-1:0] SEL_ILL_B = SELW'(14);

  logic [1:0]      r_state;
  logic            r_last_g;
  logic            r_owner;
  logic            r_err;
  logic [DWL-1:0]  r_res;
  logic [DWL-1:0]  r_in1;
  logic [DWL-1:0]  r_in2;
  logic [SHW-1:0]  r_shamt;
  logic [SELW-1:0] r_sel;

  logic            w_both;
  logic            w_grant;
  logic            w_accept;
  logic            w_illegal;
  logic            w_rsp_ready;
  logic [SELW-1:0] w_sel;
  logic [DWL-1:0]  w_a;
  logic [DWL-1:0]  w_b;
  logic [SHW-1:0]  w_shamt;

  // On a tie the port not served last wins; otherwise the lone valid port wins.
  assign w_both   = bus.req_valid_0 & bus.req_valid_1;
  assign w_grant  = w_both ? ~r_last_g : bus.req_valid_1;
  assign w_accept = (r_state == S_IDLE) & (w_grant ? bus.req_valid_1 : bus.req_valid_0);

  assign bus.req_ready_0 = rst_n & w_accept & ~w_grant;
  assign bus.req_ready_1 = rst_n & w_accept &  w_grant;

  assign w_sel   = w_grant ? bus.req_sel_1   : bus.req_sel_0;
  assign w_a     = w_grant ? bus.req_a_1     : bus.req_a_0;
  assign w_b     = w_grant ? bus.req_b_1     : bus.req_b_0;
  assign w_shamt = w_grant ? bus.req_shamt_1 : bus.req_shamt_0;

  assign w_illegal   = (r_sel == SEL_ILL_A) | (r_sel == SEL_ILL_B);
  assign w_rsp_ready = r_owner ? bus.rsp_ready_1 : bus.rsp_ready_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last_g <= 1'b1;
      r_owner  <= 1'b0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_in1    <= '0;
      r_in2    <= '0;
      r_shamt  <= '0;
      r_sel    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in1    <= w_a;
            r_in2    <= w_b;
            r_shamt  <= w_shamt;
            r_sel    <= w_sel;
            r_owner  <= w_grant;
            r_last_g <= w_grant;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Unimplemented select codes report an error with a zero result.
          r_res   <= w_illegal ? '0 : alu_out;
          r_err   <= w_illegal;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid_0 = (r_state == S_RESP) & ~r_owner;
  assign bus.rsp_valid_1 = (r_state == S_RESP) &  r_owner;
  assign bus.rsp_data    = r_res;
  assign bus.rsp_err     = r_err;

  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign alu_shamt = r_shamt;
  assign alu_sel   = r_sel;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: an external ALU model plus a response scoreboard fed at grant time.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
  localparam int DWL  = 32;
  localparam int SHW  = 5;
  localparam int SELW = 4;

  typedef struct {
    logic           port;
    logic [DWL-1:0] data;
    logic           err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DWL-1:0]  alu_in1;
  logic [DWL-1:0]  alu_in2;
  logic [SHW-1:0]  alu_shamt;
  logic [SELW-1:0] alu_sel;
  logic [DWL-1:0]  aluOut;

  exp_t sb[$];
  int   rspCycles[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  alu_share_ctrl_if #(.DWL(DWL), .SHW(SHW), .SELW(SELW)) bus ();

  alu_share_ctrl #(.DWL(DWL), .SHW(SHW), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_shamt (alu_shamt),
    .alu_sel   (alu_sel),
    .alu_out   (aluOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // External ALU: SLT is an unsigned compare.
  always_comb begin
    aluOut = '0;
    case (alu_sel)
      4'd0:    aluOut = alu_in1 + alu_in2;
      4'd1:    aluOut = alu_in1 - alu_in2;
      4'd2:    aluOut = alu_in2 << alu_shamt;
      4'd3:    aluOut = alu_in1 & alu_in2;
      4'd4:    aluOut = alu_in1 | alu_in2;
      4'd11:   aluOut = alu_in1 ^ alu_in2;
      4'd15:   aluOut = {31'd0, (alu_in1 < alu_in2)};
      default: aluOut = alu_in1 ^ 32'hA5A5_5A5A;
    endcase
  end

  // Response monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (bus.rsp_valid_0 && bus.rsp_valid_1) begin
        errors++;
        $display("[TB] FAIL dual_rsp_valid: got both rsp_valid high, expected at most one");
      end
      if ((bus.rsp_valid_0 && bus.rsp_ready_0) || (bus.rsp_valid_1 && bus.rsp_ready_1)) begin
        rspCycles.push_back(cycle);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rsp: got response port=%0d data=%0h, expected none",
                   bus.rsp_valid_1, bus.rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.rsp_valid_1 !== e.port || bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
            errors++;
            $display("[TB] FAIL rsp_match: got port=%0d data=%0h err=%0b, expected port=%0d data=%0h err=%0b",
                     bus.rsp_valid_1, bus.rsp_data, bus.rsp_err, e.port, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic pushExp(input logic p, input logic [DWL-1:0] d, input logic er);
    exp_t e;
    e.port = p;
    e.data = d;
    e.err  = er;
    sb.push_back(e);
  endtask

  task automatic setReq(input logic p, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    if (p) begin
      bus.req_sel_1 = sel; bus.req_a_1 = a; bus.req_b_1 = b; bus.req_shamt_1 = sh;
    end else begin
      bus.req_sel_0 = sel; bus.req_a_0 = a; bus.req_b_0 = b; bus.req_shamt_0 = sh;
    end
  endtask

  // Drives one request and waits (bounded) for its acceptance; returns the acceptance cycle.
  task automatic issue(input logic p, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, output int grantCycle);
    bit got;
    got = 1'b0;
    grantCycle = -1;
    setReq(p, sel, a, b, sh);
    if (p) bus.req_valid_1 = 1'b1; else bus.req_valid_0 = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (p ? bus.req_ready_1 : bus.req_ready_0) begin
        got = 1'b1;
        grantCycle = cycle;
      end
      @(posedge clk); #1;
    end
    if (p) bus.req_valid_1 = 1'b0; else bus.req_valid_0 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no req_ready on port %0d, expected acceptance", p);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
    setReq(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    setReq(1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready_0, bus.req_ready_1, bus.rsp_valid_0, bus.rsp_valid_1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got %b, expected 0000",
               {bus.req_ready_0, bus.req_ready_1, bus.rsp_valid_0, bus.rsp_valid_1});
    end
    checks++;
    if (alu_in1 !== '0 || alu_in2 !== '0 || alu_shamt !== '0 || alu_sel !== '0) begin
      errors++;
      $display("[TB] FAIL reset_alu: got %0h %0h %0h %0h, expected all 0", alu_in1, alu_in2, alu_shamt, alu_sel);
    end
    checks++;
    if (bus.rsp_data !== '0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got data=%0h err=%0b, expected 0/0", bus.rsp_data, bus.rsp_err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic expG;
    logic g;
    int   grants;
    expG = 1'b0;
    grants = 0;
    bus.rsp_ready_0 = 1'b1; bus.rsp_ready_1 = 1'b1;
    setReq(1'b0, 4'd1, 32'd10, 32'd3, 5'd0);
    setReq(1'b1, 4'd1, 32'd20, 32'd4, 5'd0);
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
    for (int i = 0; i < 60 && grants < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready_0 && bus.req_ready_1) begin
        checks++; errors++;
        $display("[TB] FAIL double_grant: got both req_ready high, expected one");
      end else if (bus.req_ready_0 || bus.req_ready_1) begin
        g = bus.req_ready_1;
        checks++;
        if (g !== expG) begin
          errors++;
          $display("[TB] FAIL grant_order: got port %0d, expected port %0d", g, expG);
        end
        pushExp(g, g ? 32'd16 : 32'd7, 1'b0);
        expG = ~g;
        grants++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    checks++;
    if (grants != 6) begin
      errors++;
      $display("[TB] FAIL contention_grants: got %0d grants, expected 6", grants);
    end
    waitDrain();
  endtask

  task automatic test_single_add();
    int startCycle;
    int gc;
    int rspCycle;
    rspCycle = -1;
    bus.rsp_ready_0 = 1'b1;
    startCycle = cycle;
    pushExp(1'b0, 32'd12, 1'b0);
    issue(1'b0, 4'd0, 32'd5, 32'd7, 5'd0, gc);
    checks++;
    if (gc != startCycle) begin
      errors++;
      $display("[TB] FAIL add_ready_cycle: got %0d, expected %0d", gc, startCycle);
    end
    for (int i = 0; i < 10 && rspCycle < 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_1) begin
        checks++; errors++;
        $display("[TB] FAIL add_rsp_valid_1: got 1, expected 0");
      end
      if (bus.rsp_valid_0) rspCycle = cycle;
    end
    @(posedge clk); #1;
    checks++;
    if (rspCycle != gc + 2) begin
      errors++;
      $display("[TB] FAIL add_latency: got rsp cycle %0d, expected %0d", rspCycle, gc + 2);
    end
    waitDrain();
  endtask

  task automatic test_backpressure();
    int gc;
    bit seen;
    seen = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    bus.rsp_ready_0 = 1'b1;
    pushExp(1'b1, 32'd16, 1'b0);
    pushExp(1'b0, 32'd123, 1'b0);
    issue(1'b1, 4'd2, 32'd0, 32'd1, 5'd4, gc);
    setReq(1'b0, 4'd0, 32'd100, 32'd23, 5'd0);
    bus.req_valid_0 = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL bp_rsp_timeout: got no rsp_valid_1, expected one");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_data !== 32'd16 || bus.req_ready_0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid=%0b data=%0h ready0=%0b, expected 1/10/0",
                 bus.rsp_valid_1, bus.rsp_data, bus.req_ready_0);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready_1 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_ready_at_hs: got 1, expected 0");
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_pending_accept: got 0, expected 1");
    end
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b0;
    waitDrain();
  endtask

  task automatic test_illegal_sel();
    int gc;
    bus.rsp_ready_0 = 1'b1;
    pushExp(1'b0, 32'd0, 1'b1);
    issue(1'b0, 4'b1101, 32'd5, 32'd7, 5'd0, gc);
    waitDrain();
    pushExp(1'b0, 32'd1, 1'b0);
    issue(1'b0, 4'd15, 32'd5, 32'd7, 5'd0, gc);
    waitDrain();
  endtask

  task automatic test_reset_midop();
    int gc;
    bus.rsp_ready_0 = 1'b1; bus.rsp_ready_1 = 1'b1;
    issue(1'b0, 4'd3, 32'h55, 32'h0F, 5'd3, gc);
    rst_n = 1'b0;
    setReq(1'b0, 4'd0, 32'd2, 32'd3, 5'd0);
    setReq(1'b1, 4'd0, 32'd4, 32'd4, 5'd0);
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_0, bus.req_ready_1, bus.rsp_valid_0, bus.rsp_valid_1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midop_handshake: got %b, expected 0000",
               {bus.req_ready_0, bus.req_ready_1, bus.rsp_valid_0, bus.rsp_valid_1});
    end
    checks++;
    if (alu_in1 !== '0 || alu_in2 !== '0 || alu_shamt !== '0 || alu_sel !== '0) begin
      errors++;
      $display("[TB] FAIL midop_alu: got %0h %0h %0h %0h, expected all 0", alu_in1, alu_in2, alu_shamt, alu_sel);
    end
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_0 || bus.rsp_valid_1) begin
        errors++;
        $display("[TB] FAIL midop_ghost_rsp: got rsp_valid %b, expected 00", {bus.rsp_valid_0, bus.rsp_valid_1});
      end
    end
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_0 !== 1'b1 || bus.req_ready_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_tie_grant: got ready %b, expected 10", {bus.req_ready_0, bus.req_ready_1});
    end
    if (bus.req_ready_0) pushExp(1'b0, 32'd5, 1'b0);
    else if (bus.req_ready_1) pushExp(1'b1, 32'd8, 1'b0);
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    waitDrain();
  endtask

  task automatic test_back_to_back();
    int grants;
    grants = 0;
    rspCycles.delete();
    bus.rsp_ready_0 = 1'b1;
    setReq(1'b0, 4'd11, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
    bus.req_valid_0 = 1'b1;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready_0) begin
        pushExp(1'b0, 32'hF0F0_0F0F, 1'b0);
        grants++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_0 = 1'b0;
    waitDrain();
    checks++;
    if (rspCycles.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d responses, expected 4", rspCycles.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rspCycles[i] - rspCycles[i-1] != 3) begin
          errors++;
          $display("[TB] FAIL b2b_spacing: got %0d cycles, expected 3", rspCycles[i] - rspCycles[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_contention();
    test_single_add();
    test_backpressure();
    test_illegal_sel();
    test_reset_midop();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
